load_store_sequencer: RTL

//  Sits between the execute stage and the byte-wide data memory (8-bit RD/WD, async read, sync write).

---
 rtl/load_store_sequencer_if.sv | 31 +++
 rtl/load_store_sequencer.sv | 131 +++++++++++++
 2 files changed

// File: rtl/load_store_sequencer_if.sv
// Request/response and byte-memory bus for the load/store sequencer.
// The slave modport is the sequencer. The master modport is the pipeline plus memory side.
interface load_store_sequencer_if #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned BYTE_WIDTH    = 8
) ();
  logic                     req_valid;
  logic                     req_ready;
  logic                     req_we;
  logic [2:0]               req_funct3;
  logic [ADDRESS_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0]    req_wdata;
  logic                     resp_valid;
  logic                     resp_err;
  logic [DATA_WIDTH-1:0]    resp_rdata;
  logic                     mem_we;
  logic [ADDRESS_WIDTH-1:0] mem_a;
  logic [BYTE_WIDTH-1:0]    mem_wd;
  logic [BYTE_WIDTH-1:0]    mem_rd;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
    input  req_ready, resp_valid, resp_err, resp_rdata, mem_we, mem_a, mem_wd
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
    output req_ready, resp_valid, resp_err, resp_rdata, mem_we, mem_a, mem_wd
  );
endinterface

// File: rtl/load_store_sequencer.sv
// Splits one RV32I load/store into 1, 2 or 4 little-endian byte accesses on a byte-wide memory.
// Loads are assembled and then sign- or zero-extended in the single response cycle.
module load_store_sequencer #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned BYTE_WIDTH    = 8
) (
  input logic                   clk,
  input logic                   rst_n,
  load_store_sequencer_if.slave bus
);
  localparam int unsigned HalfWidth = 2 * BYTE_WIDTH;

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e                   state_q, state_d;
  logic [1:0]               cnt_q, cnt_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [ADDRESS_WIDTH-1:0] mem_a_q, mem_a_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]    data_q, data_d;
  logic [2:0]               funct3_q, funct3_d;
  logic                     we_q, we_d;
  logic                     err_q, err_d;

  logic                     legal;
  logic [1:0]               last_cnt;
  logic [ADDRESS_WIDTH-1:0] beat_addr;

  // Stores only have byte/half/word sizes; loads add the unsigned byte/half variants.
  always_comb begin
    if (bus.req_we) begin
      legal = bus.req_funct3 inside {3'b000, 3'b001, 3'b010};
    end else begin
      legal = bus.req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    end
  end

  assign last_cnt  = funct3_q[1] ? 2'd3 : (funct3_q[0] ? 2'd1 : 2'd0);
  assign beat_addr = addr_q + ADDRESS_WIDTH'(cnt_q);

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    addr_d         = addr_q;
    mem_a_d        = mem_a_q;
    wdata_d        = wdata_q;
    data_d         = data_q;
    funct3_d       = funct3_q;
    we_d           = we_q;
    err_d          = err_q;
    bus.req_ready  = (state_q == StIdle);
    bus.resp_valid = 1'b0;
    bus.resp_err   = 1'b0;
    bus.resp_rdata = '0;
    bus.mem_we     = 1'b0;
    bus.mem_a      = mem_a_q;
    bus.mem_wd     = '0;

    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          addr_d   = bus.req_addr;
          wdata_d  = bus.req_wdata;
          funct3_d = bus.req_funct3;
          we_d     = bus.req_we;
          err_d    = !legal;
          cnt_d    = 2'd0;
          data_d   = '0;
          state_d  = legal ? StAccess : StResp;
        end
      end
      StAccess: begin
        bus.mem_a  = beat_addr;
        mem_a_d    = beat_addr;
        bus.mem_we = we_q;
        bus.mem_wd = wdata_q[BYTE_WIDTH*cnt_q +: BYTE_WIDTH];
        if (!we_q) begin
          data_d[BYTE_WIDTH*cnt_q +: BYTE_WIDTH] = bus.mem_rd;
        end
        if (cnt_q == last_cnt) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      StResp: begin
        bus.resp_valid = 1'b1;
        bus.resp_err   = err_q;
        if (!err_q && !we_q) begin
          unique case (funct3_q)
            3'b000: bus.resp_rdata = {{(DATA_WIDTH-BYTE_WIDTH){data_q[BYTE_WIDTH-1]}},
                                      data_q[BYTE_WIDTH-1:0]};
            3'b001: bus.resp_rdata = {{(DATA_WIDTH-HalfWidth){data_q[HalfWidth-1]}},
                                      data_q[HalfWidth-1:0]};
            3'b100: bus.resp_rdata = {{(DATA_WIDTH-BYTE_WIDTH){1'b0}}, data_q[BYTE_WIDTH-1:0]};
            3'b101: bus.resp_rdata = {{(DATA_WIDTH-HalfWidth){1'b0}}, data_q[HalfWidth-1:0]};
            default: bus.resp_rdata = data_q;
          endcase
        end
        cnt_d   = 2'd0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= 2'd0;
      addr_q   <= '0;
      mem_a_q  <= '0;
      wdata_q  <= '0;
      data_q   <= '0;
      funct3_q <= 3'b000;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      mem_a_q  <= mem_a_d;
      wdata_q  <= wdata_d;
      data_q   <= data_d;
      funct3_q <= funct3_d;
      we_q     <= we_d;
      err_q    <= err_d;
    end
  end
endmodule
